// File: rtl/tart_acquire_pkg.sv
// Shared definitions for the acquisition burst writer.
//   state_t        : burst-writer FSM state encoding
//   MEM_DW         : SDRAM data-bus width
//   DEFAULT_BURST  : default words per SDRAM write burst
//   DEFAULT_ADDR   : default SDRAM word-address width
package tart_acquire_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_BURST = 2'b10
  } state_t;

  localparam int MEM_DW        = 32;
  localparam int DEFAULT_BURST = 8;
  localparam int DEFAULT_ADDR  = 21;

endpackage

// File: rtl/acquire_fifo.sv
// Single-clock sample FIFO, 2^ABITS entries of WIDTH bits, distributed-RAM
// storage with asynchronous read so the head and the entry behind it are
// visible without a read-latency cycle.
// Ports:
//   clock_i, reset_ni : clock, asynchronous active-low reset
//   clear_i           : synchronous flush (wins over push/pop)
//   push_i, data_i    : write request and data (caller guarantees !full or pop)
//   pop_i             : read request (caller guarantees !empty)
//   head_o            : entry at the read pointer
//   next_o            : entry one past the read pointer
//   level_o           : occupancy, 0 .. 2^ABITS
//   full_o, empty_o   : occupancy flags
module acquire_fifo #(
  parameter int WIDTH = 24,
  parameter int ABITS = 4
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic [ABITS:0]   level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << ABITS;

  logic [WIDTH-1:0] mem_array [DEPTH];
  logic [ABITS-1:0] wr_ptr_reg;
  logic [ABITS-1:0] rd_ptr_reg;
  logic [ABITS-1:0] rd_ptr_next;
  logic [ABITS:0]   count_reg;

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clock_i) begin
    if (push_i && !clear_i) begin
      mem_array[wr_ptr_reg] <= data_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_reg <= wr_ptr_reg + ABITS'(1);
      end
      if (pop_i) begin
        rd_ptr_reg <= rd_ptr_reg + ABITS'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_reg <= count_reg + (ABITS+1)'(1);
        2'b01:   count_reg <= count_reg - (ABITS+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_ptr_next = rd_ptr_reg + ABITS'(1);
  assign head_o      = mem_array[rd_ptr_reg];
  assign next_o      = mem_array[rd_ptr_next];
  assign level_o     = count_reg;
  assign full_o      = count_reg[ABITS];
  assign empty_o     = (count_reg == '0);

endmodule

// File: rtl/acquire_burst_writer.sv
// Buffers the capture sample stream in a small FIFO and drains it to the
// SDRAM controller as fixed-length write bursts (request/grant, then
// write beats qualified by ready) at sequential, wrapping word addresses.
// Ports:
//   clock_i, reset_ni   : clock, asynchronous active-low reset
//   enable_i            : capture enable; samples ignored while low
//   clear_i             : flush FIFO, zero address, clear flags (IDLE only)
//   valid_i, data_i     : sample strobe and WIDTH-bit sample
//   mem_req_o/mem_gnt_i : burst request and one-cycle grant
//   mem_wr_o/mem_rdy_i  : beat valid and controller acceptance
//   mem_adr_o/mem_dat_o : beat word address and zero-padded 32-bit data
//   level_o             : FIFO occupancy
//   overflow_o          : sticky, a sample was dropped on a full FIFO
//   wrapped_o           : sticky, the address rolled over to zero
// DELAY is kept for compatibility with simulation wrappers; it does not
// change this logic.
module acquire_burst_writer
  import tart_acquire_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int BURST = DEFAULT_BURST,
  parameter int ABITS = 4,
  parameter int ADDR  = DEFAULT_ADDR,
  parameter int DELAY = 3
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_wr_o,
  input  logic              mem_rdy_i,
  output logic [ADDR-1:0]   mem_adr_o,
  output logic [MEM_DW-1:0] mem_dat_o,
  output logic [ABITS:0]    level_o,
  output logic              overflow_o,
  output logic              wrapped_o
);

  localparam int              CW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [ABITS:0]  BURST_LVL = (ABITS+1)'(BURST);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST - 1);
  localparam logic [ADDR-1:0] ADR_MAX   = '1;

  // Reject parameter sets the burst logic cannot honour.
  if (BURST < 1 || BURST > (1 << ABITS) / 2 || (BURST & (BURST - 1)) != 0 ||
      WIDTH > MEM_DW || DELAY < 0) begin : g_bad_params
    $error("acquire_burst_writer: illegal parameter combination");
  end

  state_t            state_reg;
  logic              req_reg;
  logic              wr_reg;
  logic [ADDR-1:0]   adr_reg;
  logic [MEM_DW-1:0] dat_reg;
  logic              overflow_reg;
  logic              wrapped_reg;
  logic [CW-1:0]     beat_reg;

  logic [ABITS:0]    fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_head;
  logic [WIDTH-1:0]  fifo_next;

  logic sample_in;
  logic clear_ok;
  logic beat_done;
  logic fifo_push;
  logic fifo_pop;
  logic drop;

  assign sample_in = enable_i & valid_i;
  assign clear_ok  = clear_i & (state_reg == ST_IDLE);
  assign beat_done = (state_reg == ST_BURST) & wr_reg & mem_rdy_i;
  assign fifo_pop  = beat_done & ~fifo_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign fifo_push = sample_in & ~clear_ok & (~fifo_full | fifo_pop);
  assign drop      = sample_in & ~clear_ok & fifo_full & ~fifo_pop;

  acquire_fifo #(
    .WIDTH (WIDTH),
    .ABITS (ABITS)
  ) u_fifo (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .clear_i  (clear_ok),
    .push_i   (fifo_push),
    .data_i   (data_i),
    .pop_i    (fifo_pop),
    .head_o   (fifo_head),
    .next_o   (fifo_next),
    .level_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg    <= ST_IDLE;
      req_reg      <= 1'b0;
      wr_reg       <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      overflow_reg <= 1'b0;
      wrapped_reg  <= 1'b0;
      beat_reg     <= '0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (clear_i) begin
            adr_reg      <= '0;
            overflow_reg <= 1'b0;
            wrapped_reg  <= 1'b0;
          end else if (fifo_level >= BURST_LVL) begin
            state_reg <= ST_REQ;
            req_reg   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            state_reg <= ST_BURST;
            req_reg   <= 1'b0;
            wr_reg    <= 1'b1;
            dat_reg   <= MEM_DW'(fifo_head);
            beat_reg  <= '0;
          end
        end
        ST_BURST: begin
          if (beat_done) begin
            adr_reg <= adr_reg + ADDR'(1);
            if (adr_reg == ADR_MAX) begin
              wrapped_reg <= 1'b1;
            end
            if (beat_reg == LAST_BEAT) begin
              wr_reg    <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              beat_reg <= beat_reg + CW'(1);
              // The head is being popped this cycle, so the next beat
              // carries the entry behind it.
              dat_reg  <= MEM_DW'(fifo_next);
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          req_reg   <= 1'b0;
          wr_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o  = req_reg;
  assign mem_wr_o   = wr_reg;
  assign mem_adr_o  = adr_reg;
  assign mem_dat_o  = dat_reg;
  assign level_o    = fifo_level;
  assign overflow_o = overflow_reg;
  assign wrapped_o  = wrapped_reg;

endmodule
